adder_4bit: RTL and testbench



---
 rtl/arith_pkg.sv | 11 +
 rtl/adder_cla_group.sv | 33 +++
 rtl/adder_4bit.sv | 72 +++++++
 tb/tb_adder_4bit.sv | 118 +++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic constants and helpers for the grouped carry-lookahead adders.
package arith_pkg;

  localparam int unsigned GROUP_W = 4;

  // Number of 4-bit lookahead groups needed for an operand of the given width.
  function automatic int unsigned group_count(input int unsigned width);
    return width / GROUP_W;
  endfunction

endpackage

// File: rtl/adder_cla_group.sv
// 4-bit carry-lookahead group: local sums plus group generate/propagate and carry-out.
module adder_cla_group (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       g,
  output logic       p,
  output logic       cout
);

  logic [3:0] gen;
  logic [3:0] prop;
  logic [3:0] c;

  assign gen  = a & b;
  assign prop = a ^ b;

  // Every internal carry is a flat two-level function of gen/prop/cin.
  assign c[0] = cin;
  assign c[1] = gen[0] | (prop[0] & cin);
  assign c[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cin);
  assign c[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
              | (prop[2] & prop[1] & prop[0] & cin);

  assign g = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
           | (prop[3] & prop[2] & prop[1] & gen[0]);
  assign p = &prop;

  assign cout = g | (p & cin);
  assign s    = prop ^ c;

endmodule

// File: rtl/adder_4bit.sv
// Registered unsigned adder: full-precision sum of two WIDTH-bit operands, one cycle latency.
module adder_4bit
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum,
  output logic             out_valid
);

  localparam int unsigned NGRP = group_count(WIDTH);

  logic [NGRP:0]    carry;
  logic [NGRP-1:0]  grp_g;
  logic [NGRP-1:0]  grp_p;
  logic [NGRP-1:0]  grp_cout;
  logic [WIDTH-1:0] part_sum;
  logic [WIDTH:0]   add_res;
  logic [WIDTH:0]   sum_d;
  logic [WIDTH:0]   sum_q;
  logic             valid_q;

  assign carry[0] = 1'b0;

  // Group carries ripple between groups using each group's G/P terms.
  for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
    adder_cla_group u_grp (
      .a    (a[gi*GROUP_W +: GROUP_W]),
      .b    (b[gi*GROUP_W +: GROUP_W]),
      .cin  (carry[gi]),
      .s    (part_sum[gi*GROUP_W +: GROUP_W]),
      .g    (grp_g[gi]),
      .p    (grp_p[gi]),
      .cout (grp_cout[gi])
    );

    assign carry[gi+1] = grp_g[gi] | (grp_p[gi] & carry[gi]);

    a_cout_consistent : assert property (
      @(posedge clk) disable iff (!rst_n) in_valid |-> (grp_cout[gi] == carry[gi+1])
    );
  end

  assign add_res = {carry[NGRP], part_sum};

  // Ignored operands never reach the register, so X on them cannot leak into sum.
  always_comb begin
    sum_d = sum_q;
    if (in_valid) begin
      sum_d = add_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      valid_q <= in_valid;
    end
  end

  assign sum       = sum_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_adder_4bit.sv
// Directed bench for adder_4bit: reset, carries, hold, async reset and all 256 operand pairs.
module tb_adder_4bit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic [4:0] sum;
  logic       out_valid;

  int unsigned n_cmp;
  int unsigned n_bad;

  adder_4bit #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .sum       (sum),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive one operand pair at the falling edge, then check just after the next rising edge.
  task automatic step(input logic v, input logic [3:0] av, input logic [3:0] bv,
                      input logic [4:0] exp_sum, input logic exp_ov, input string tag);
    @(negedge clk);
    in_valid = v;
    a        = av;
    b        = bv;
    @(posedge clk);
    #1;
    check({tag, ".sum"}, 32'(sum), 32'(exp_sum));
    check({tag, ".ov"},  32'(out_valid), 32'(exp_ov));
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = 4'd0;
    b        = 4'd0;

    repeat (3) @(posedge clk);
    #1;
    check("rst.sum", 32'(sum), 32'd0);
    check("rst.ov",  32'(out_valid), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst.sum", 32'(sum), 32'd0);
    check("post_rst.ov",  32'(out_valid), 32'd0);

    // Basic adds and carry-out cases
    step(1'b1, 4'd1,  4'd2,  5'd3,  1'b1, "add_1_2");
    step(1'b1, 4'd4,  4'd5,  5'd9,  1'b1, "add_4_5");
    step(1'b1, 4'd15, 4'd1,  5'd16, 1'b1, "add_15_1");
    step(1'b1, 4'd10, 4'd11, 5'd21, 1'b1, "add_10_11");

    // Extremes, then hold with operands changing under in_valid=0
    step(1'b1, 4'd0,  4'd0,  5'd0,  1'b1, "add_0_0");
    step(1'b1, 4'd15, 4'd15, 5'd30, 1'b1, "add_15_15");
    step(1'b0, 4'd7,  4'd9,  5'd30, 1'b0, "hold_a");
    step(1'b0, 4'd3,  4'd12, 5'd30, 1'b0, "hold_b");

    // Async reset asserted mid-cycle while sum=21
    step(1'b1, 4'd10, 4'd11, 5'd21, 1'b1, "pre_async");
    #2;
    rst_n = 1'b0;
    #1;
    check("async.sum", 32'(sum), 32'd0);
    check("async.ov",  32'(out_valid), 32'd0);

    // Valid operands during reset must be discarded
    in_valid = 1'b1;
    a        = 4'd15;
    b        = 4'd15;
    @(posedge clk);
    #1;
    check("in_rst.sum", 32'(sum), 32'd0);
    check("in_rst.ov",  32'(out_valid), 32'd0);

    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step(1'b1, 4'd3, 4'd4, 5'd7, 1'b1, "add_3_4");
    step(1'b0, 4'd9, 4'd9, 5'd7, 1'b0, "idle_after");

    // All 256 pairs back-to-back
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        step(1'b1, 4'(i), 4'(j), 5'(i + j), 1'b1, $sformatf("exh_%0d_%0d", i, j));
      end
    end

    @(negedge clk);
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
